// File: rtl/prim_lfsr_rng.sv
// Galois LFSR random word generator: StepsPerWord advances per word, small output FIFO,
// reseed handshake, gated entropy injection, lockup recovery and a repetition alert.
module prim_lfsr_rng #(
    parameter int unsigned         LfsrDw       = 32,
    parameter int unsigned         OutDw        = 16,
    parameter int unsigned         EntropyDw    = 8,
    parameter int unsigned         StepsPerWord = 16,
    parameter logic [LfsrDw-1:0]   Coeffs       = LfsrDw'(32'h80000057),
    parameter logic [LfsrDw-1:0]   DefaultSeed  = LfsrDw'(32'h1),
    parameter int unsigned         FifoDepth    = 2,
    parameter int unsigned         RepThresh    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 seed_valid_i,
    output logic                 seed_ready_o,
    input  logic [LfsrDw-1:0]    seed_i,
    input  logic                 entropy_valid_i,
    input  logic [EntropyDw-1:0] entropy_i,
    output logic                 rnd_valid_o,
    input  logic                 rnd_ready_i,
    output logic [OutDw-1:0]     rnd_o,
    output logic                 busy_o,
    output logic [7:0]           lockup_cnt_o,
    output logic                 rep_alert_o
);

    localparam int unsigned StepW = $clog2(StepsPerWord + 1);
    localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW  = $clog2(FifoDepth + 1);
    localparam int unsigned RepW  = $clog2(RepThresh + 1);

    localparam logic [StepW-1:0] StepLast = StepW'(StepsPerWord - 1);
    localparam logic [PtrW-1:0]  PtrLast  = PtrW'(FifoDepth - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FifoDepth);
    localparam logic [RepW-1:0]  RepMax   = RepW'(RepThresh);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StSeed = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [LfsrDw-1:0] lfsr_q, lfsr_d;
    logic [StepW-1:0]  step_q, step_d;
    logic [7:0]        lockup_q, lockup_d;
    logic [RepW-1:0]   rep_q, rep_d;
    logic [OutDw-1:0]  last_q, last_d;
    logic              alert_q, alert_d;

    logic [OutDw-1:0]  mem_q [FifoDepth];
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]   cnt_q;

    logic              push, pop, flush, lockup_inc, pop_ok;
    logic [LfsrDw-1:0] step_raw, step_val;
    logic              step_zero;
    logic [OutDw-1:0]  push_word;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : PtrW'(p + PtrW'(1));
    endfunction

    // One Galois step with optional entropy; an all-zero result is replaced by DefaultSeed
    assign step_raw  = (lfsr_q >> 1) ^ ({LfsrDw{lfsr_q[0]}} & Coeffs)
                     ^ (entropy_valid_i ? LfsrDw'(entropy_i) : '0);
    assign step_zero = (step_raw == '0);
    assign step_val  = step_zero ? DefaultSeed : step_raw;
    assign push_word = step_val[OutDw-1:0];
    assign pop_ok    = (cnt_q != '0) && rnd_ready_i;

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        step_d     = step_q;
        lockup_d   = lockup_q;
        rep_d      = rep_q;
        last_d     = last_q;
        alert_d    = alert_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        lockup_inc = 1'b0;

        if (seed_valid_i && (state_q != StSeed)) begin
            state_d    = StSeed;
            lfsr_d     = (seed_i == '0) ? DefaultSeed : seed_i;
            lockup_inc = (seed_i == '0);
            step_d     = '0;
            flush      = 1'b1;
            rep_d      = '0;
            last_d     = '0;
            alert_d    = 1'b0;
        end else begin
            pop = pop_ok;
            case (state_q)
                StIdle: begin
                    if (en_i) state_d = StRun;
                end
                StRun: begin
                    if (!en_i) begin
                        state_d = StIdle;
                    end else if (step_q != StepLast) begin
                        lfsr_d     = step_val;
                        step_d     = StepW'(step_q + StepW'(1));
                        lockup_inc = step_zero;
                    end else if ((cnt_q != CntFull) || pop_ok) begin
                        lfsr_d     = step_val;
                        step_d     = '0;
                        push       = 1'b1;
                        lockup_inc = step_zero;
                    end
                end
                StSeed: begin
                    state_d = en_i ? StRun : StIdle;
                end
                default: state_d = StIdle;
            endcase

            // Repetition health test runs on every pushed word
            if (push) begin
                if (push_word == last_q) begin
                    rep_d = (rep_q == RepMax) ? rep_q : RepW'(rep_q + RepW'(1));
                end else begin
                    rep_d = RepW'(1);
                end
                last_d  = push_word;
                alert_d = alert_q || (rep_d == RepMax);
            end
        end

        if (lockup_inc && (lockup_q != 8'hFF)) lockup_d = lockup_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            lfsr_q   <= DefaultSeed;
            step_q   <= '0;
            lockup_q <= '0;
            rep_q    <= '0;
            last_q   <= '0;
            alert_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            step_q   <= step_d;
            lockup_q <= lockup_d;
            rep_q    <= rep_d;
            last_q   <= last_d;
            alert_q  <= alert_d;
        end
    end

    // Output FIFO; a push into an empty FIFO becomes visible the following cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(FifoDepth); i++) mem_q[i] <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_word;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   cnt_q <= CntW'(cnt_q + CntW'(1));
                2'b01:   cnt_q <= CntW'(cnt_q - CntW'(1));
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign seed_ready_o = (state_q != StSeed);
    assign busy_o       = (state_q == StRun);
    assign rnd_valid_o  = (cnt_q != '0);
    assign rnd_o        = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign lockup_cnt_o = lockup_q;
    assign rep_alert_o  = alert_q;

endmodule
